// File: rtl/seq_scan_ctrl_pkg.sv
// Purpose : shared encodings for the scan controller and its 0111110 detector.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package seq_scan_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // Detector states: the state number is the length of the matched prefix
  // of 0111110. DET_S7 means the full pattern has just been seen.
  typedef enum logic [2:0] {
    DET_S0 = 3'b000,
    DET_S1 = 3'b001,
    DET_S2 = 3'b010,
    DET_S3 = 3'b011,
    DET_S4 = 3'b100,
    DET_S5 = 3'b101,
    DET_S6 = 3'b110,
    DET_S7 = 3'b111
  } det_state_e;

  // Length of the detected pattern 0111110
  localparam int PAT_LEN = 7;

endpackage : seq_scan_ctrl_pkg

// File: rtl/seq_det_sync.sv
// Purpose : Moore detector for the serial pattern 0111110 (overlapping).
// Latency : w rises one cycle after the final 0 of the pattern is sampled.
// Backpr. : none; en=0 freezes the state, clr returns it to 000.
//
// Ports:
//   clk  - clock, state updates on posedge
//   rst  - synchronous active-high reset (state -> 000)
//   clr  - synchronous clear (state -> 000), lower priority than rst
//   en   - when low the state holds regardless of inp
//   inp  - serial input bit
//   w    - match flag, high only in state 111
module seq_det_sync
  import seq_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic inp,
  output logic w
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (en) begin
      unique case (state_q)
        // A leading 1 cannot start the pattern, so stay put.
        DET_S0: state_d = inp ? DET_S0 : DET_S1;
        DET_S1: state_d = inp ? DET_S2 : DET_S1;
        DET_S2: state_d = inp ? DET_S3 : DET_S1;
        DET_S3: state_d = inp ? DET_S4 : DET_S1;
        DET_S4: state_d = inp ? DET_S5 : DET_S1;
        DET_S5: state_d = inp ? DET_S6 : DET_S1;
        // A seventh 1 breaks the run; no suffix of 0111111 is a prefix.
        DET_S6: state_d = inp ? DET_S0 : DET_S7;
        // The trailing 0 of a match doubles as the leading 0 of the next.
        DET_S7: state_d = inp ? DET_S2 : DET_S1;
        default: state_d = DET_S0;
      endcase
    end
  end

  assign w = (state_q == DET_S7);

endmodule : seq_det_sync

// File: rtl/seq_scan_ctrl.sv
// Purpose : serialise a parallel word MSB-first into the 0111110 detector and count matches.
// Latency : start accepted at edge T -> done pulse in the cycle after edge T+WORD_W+1.
// Backpr. : start is only honoured in IDLE; starts while busy are dropped.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - scan request, sampled only in IDLE
//   data_in    - word to scan, captured in the accepting cycle
//   busy       - high in SHIFT, FLUSH and DONE
//   done       - one-cycle pulse when match_cnt is final
//   match_cnt  - saturating match count of the last scan, held until next accept
//   bit_out    - serial bit fed to the detector this cycle
//   bit_valid  - high while bit_out carries word data (SHIFT)
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              bit_out,
  output logic              bit_valid
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic det_clr;
  logic det_en;
  logic det_inp;
  logic det_w;

  seq_det_sync u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .inp (det_inp),
    .w   (det_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    det_inp   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = data_in;
          idx_d   = '0;
          cnt_d   = '0;
          det_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = shreg_q[WORD_W-1];
        det_en    = 1'b1;
        det_inp   = shreg_q[WORD_W-1];
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        idx_d     = idx_q + IDX_W'(1);
        if (det_w && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_FLUSH;
        end
      end

      // Detector is frozen here; this cycle only harvests the w produced
      // by the last shifted bit.
      ST_FLUSH: begin
        busy = 1'b1;
        if (det_w && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign match_cnt = cnt_q;

endmodule : seq_scan_ctrl

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: stimulus pushes expected counts, done
// cycles and serial bits; independent monitors pop and compare.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] data_in;

  logic              busy, done, bit_out, bit_valid;
  logic [CNT_W-1:0]  match_cnt;

  logic              busy1, done1, bit_out1, bit_valid1;
  logic [0:0]        match_cnt1;

  seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  // Narrow-counter copy driven identically, to observe saturation at 1.
  seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy1),
    .done      (done1),
    .match_cnt (match_cnt1),
    .bit_out   (bit_out1),
    .bit_valid (bit_valid1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    int dcyc;
  } exp_t;

  exp_t q0[$];
  int   q1[$];
  bit   bq[$];
  bit   bit_chk_en = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("match_cnt", int'(match_cnt), e.cnt);
        chk("done_cycle", cyc, e.dcyc);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_w1: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        int e1;
        e1 = q1.pop_front();
        chk("match_cnt_w1", int'(match_cnt1), e1);
        chk("busy_w1_at_done", int'(busy1), 1);
        chk("bit_valid_w1_at_done", int'(bit_valid1), 0);
        chk("bit_out_w1_at_done", int'(bit_out1), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bit_chk_en && bit_valid) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got bit_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("bit_out", int'(bit_out), int'(bq.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input logic [WORD_W-1:0] w, input int exp_cnt, input int dcyc);
    exp_t e;
    e.cnt  = exp_cnt;
    e.dcyc = dcyc;
    q0.push_back(e);
    q1.push_back(exp_cnt > 1 ? 1 : exp_cnt);
    for (int i = WORD_W - 1; i >= 0; i--) bq.push_back(w[i]);
  endtask

  // Assumes the DUT is idle; start is sampled at the next posedge (edge A),
  // so done is expected in the cycle after edge A+WORD_W+1.
  task automatic issue(input logic [WORD_W-1:0] w, input int exp_cnt);
    @(negedge clk);
    data_in = w;
    start   = 1'b1;
    push_word(w, exp_cnt, cyc + 1 + WORD_W + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && (q0.size() != 0 || q1.size() != 0 || bq.size() != 0); i++)
      @(negedge clk);
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0 || bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d pending entries expected 0", name,
               q0.size() + q1.size() + bq.size());
      q0.delete();
      q1.delete();
      bq.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int dn;
    int d1;

    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_bit_out", int'(bit_out), 0);

    // Single match, pattern at the top of the word
    issue(16'h7C00, 1);
    drain("7C00");
    // Six ones: run too long, no match
    issue(16'h7E00, 0);
    drain("7E00");
    issue(16'hFFFF, 0);
    drain("FFFF");
    issue(16'h0000, 0);
    drain("0000");
    // Overlapping matches: 2 (saturates to 1 on the narrow copy)
    issue(16'h7DF0, 2);
    drain("7DF0");

    // Start while busy is dropped; count of the first word stands
    issue(16'h7C00, 1);
    repeat (3) @(negedge clk);
    data_in = 16'h0000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignored_start");
    repeat (3) @(negedge clk);
    chk("cnt_held_idle", int'(match_cnt), 1);

    // Reset mid-scan after a match was already counted
    bit_chk_en = 1'b0;
    @(negedge clk);
    data_in = 16'h7C00;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_abort_cnt", int'(match_cnt), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_bit_valid", int'(bit_valid), 0);
    chk("abort_match_cnt", int'(match_cnt), 0);
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    bit_chk_en = 1'b1;

    // start held high: back-to-back scans, one IDLE cycle between them
    @(negedge clk);
    data_in = 16'h7C00;
    start   = 1'b1;
    d1 = cyc + 1 + WORD_W + 1;
    push_word(16'h7C00, 1, d1);
    push_word(16'h7DF0, 2, d1 + WORD_W + 3);
    @(negedge clk);
    data_in = 16'h7DF0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("b2b_first_done_seen", int'(done), 1);
    @(negedge clk);
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_idle_cnt_held", int'(match_cnt), 1);
    @(negedge clk);
    chk("b2b_second_accept_busy", int'(busy), 1);
    chk("b2b_cnt_cleared", int'(match_cnt), 0);
    start = 1'b0;
    drain("b2b");

    chk("scoreboard_empty", q0.size() + q1.size() + bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_scan_ctrl
